// File: rtl/csr_counter_pkg.sv
// Address map and shared types for the performance-counter bank.
package csr_counter_pkg;

    localparam logic [11:0] CSR_MCYCLE           = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET         = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB00;
    localparam logic [11:0] CSR_MHPMEVENT_BASE   = 12'h320;
    localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;
    localparam logic [11:0] CSR_USER_SHADOW_OFS  = 12'h100;
    localparam logic [11:0] CSR_HI_OFS           = 12'h080;

    // Every counter group occupies a 32-entry block; the low 5 address bits are the index.
    localparam logic [11:0] CSR_BLOCK_MASK       = 12'hFE0;
    localparam int          HPM_FIRST            = 3;

    typedef logic [4:0] event_sel_t;

    function automatic logic ctr_implemented(input logic [4:0] idx, input int num_hpm);
        return (idx == 5'(CSR_MCYCLE - CSR_MHPMCOUNTER_BASE))
            || (idx == 5'(CSR_MINSTRET - CSR_MHPMCOUNTER_BASE))
            || ((int'(idx) >= HPM_FIRST) && (int'(idx) < HPM_FIRST + num_hpm));
    endfunction

endpackage

// File: rtl/csr_counter_slice.sv
// One counter of the bank: 32-bit half writes take priority over the increment.
// Increments wrap silently at 2^COUNTER_W-1.
module csr_counter_slice #(
    parameter int COUNTER_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [COUNTER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (we_lo || we_hi) begin
            if (we_lo) cnt[31:0] <= wdata;
            if (we_hi) cnt[COUNTER_W-1:32] <= wdata[COUNTER_W-33:0];
        end else if (inc) begin
            cnt <= cnt + COUNTER_W'(1);
        end
    end

    assign lo = cnt[31:0];
    assign hi = 32'(cnt[COUNTER_W-1:32]);

endmodule

// File: rtl/csr_counter_bank.sv
// mcycle / minstret / mhpmcounterN bank with event selectors and mcountinhibit.
// Reads are combinational; writes and increments land on the next clock edge.
module csr_counter_bank
    import csr_counter_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int COUNTER_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_exe,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  csr_we,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_hit
);

    localparam int          IDX_CYCLE   = int'(CSR_MCYCLE - CSR_MHPMCOUNTER_BASE);
    localparam int          IDX_INSTRET = int'(CSR_MINSTRET - CSR_MHPMCOUNTER_BASE);
    localparam logic [31:0] INH_MASK    = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

    logic [11:0] blk;
    logic [4:0]  idx;
    logic        sel_m_lo, sel_m_hi, sel_u_lo, sel_u_hi, sel_evt, sel_inh, ctr_ok;
    logic        wr_lo, wr_hi;

    assign blk      = csr_addr & CSR_BLOCK_MASK;
    assign idx      = csr_addr[4:0];
    assign ctr_ok   = ctr_implemented(idx, NUM_HPM);
    assign sel_m_lo = (blk == CSR_MHPMCOUNTER_BASE);
    assign sel_m_hi = (blk == CSR_MHPMCOUNTER_BASE + CSR_HI_OFS);
    assign sel_u_lo = (blk == CSR_MHPMCOUNTER_BASE + CSR_USER_SHADOW_OFS);
    assign sel_u_hi = (blk == CSR_MHPMCOUNTER_BASE + CSR_USER_SHADOW_OFS + CSR_HI_OFS);
    assign sel_inh  = (csr_addr == CSR_MCOUNTINHIBIT);
    assign sel_evt  = (blk == CSR_MHPMEVENT_BASE) && (int'(idx) >= HPM_FIRST) && ctr_ok;
    assign wr_lo    = csr_we && sel_m_lo && ctr_ok;
    assign wr_hi    = csr_we && sel_m_hi && ctr_ok;

    event_sel_t  evt_q [32];
    logic [31:0] inh_q;
    logic [31:0] ev_ext;

    // Bit 0 is a hard zero so selector 0 never counts; selectors past NUM_EVENTS hit zero padding.
    assign ev_ext = 32'({events, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_q <= '0;
            for (int i = 0; i < 32; i++) evt_q[i] <= '0;
        end else if (csr_we) begin
            if (sel_inh) inh_q <= csr_wdata & INH_MASK;
            for (int i = 0; i < 32; i++) begin
                if (sel_evt && (idx == 5'(i))) evt_q[i] <= csr_wdata[4:0];
            end
        end
    end

    logic [31:0] ctr_lo [32];
    logic [31:0] ctr_hi [32];

    for (genvar n = 0; n < 32; n++) begin : g_ctr
        if (n == IDX_CYCLE || n == IDX_INSTRET
            || (n >= HPM_FIRST && n < HPM_FIRST + NUM_HPM)) begin : g_impl
            logic inc;
            if (n == IDX_CYCLE) begin : g_cyc
                assign inc = !inh_q[n];
            end else if (n == IDX_INSTRET) begin : g_ret
                assign inc = ins_exe && !inh_q[n];
            end else begin : g_hpm
                assign inc = ev_ext[evt_q[n]] && !inh_q[n];
            end

            csr_counter_slice #(.COUNTER_W(COUNTER_W)) u_slice (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc),
                .we_lo (wr_lo && (idx == 5'(n))),
                .we_hi (wr_hi && (idx == 5'(n))),
                .wdata (csr_wdata),
                .lo    (ctr_lo[n]),
                .hi    (ctr_hi[n])
            );
        end else begin : g_none
            assign ctr_lo[n] = '0;
            assign ctr_hi[n] = '0;
        end
    end

    always_comb begin
        csr_hit   = 1'b0;
        csr_rdata = '0;
        if ((sel_m_lo || sel_u_lo) && ctr_ok) begin
            csr_hit   = 1'b1;
            csr_rdata = ctr_lo[idx];
        end else if ((sel_m_hi || sel_u_hi) && ctr_ok) begin
            csr_hit   = 1'b1;
            csr_rdata = ctr_hi[idx];
        end else if (sel_inh) begin
            csr_hit   = 1'b1;
            csr_rdata = inh_q;
        end else if (sel_evt) begin
            csr_hit   = 1'b1;
            csr_rdata = 32'(evt_q[idx]);
        end
    end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Two banks (64-bit and 40-bit counters) share stimulus; both are compared each read
// against an event-level model of the counter rules.
module tb_csr_counter_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_exe = 1'b0;
    logic [7:0]  events = '0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] rdata64, rdata40;
    logic        hit64, hit40;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_counter_bank #(.NUM_HPM(4), .NUM_EVENTS(8), .COUNTER_W(64)) dut (
        .clk(clk), .rst(rst), .ins_exe(ins_exe), .events(events), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata64), .csr_hit(hit64)
    );

    csr_counter_bank #(.NUM_HPM(4), .NUM_EVENTS(8), .COUNTER_W(40)) dut40 (
        .clk(clk), .rst(rst), .ins_exe(ins_exe), .events(events), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata40), .csr_hit(hit40)
    );

    // Reference state: index 0 is the 64-bit bank, index 1 the 40-bit bank.
    longint unsigned m_ctr [2][32];
    int              m_evt [32];
    logic [31:0]     m_inh;

    function automatic longint unsigned wmask(int w);
        return (w == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h00FF_FFFF_FFFF;
    endfunction

    function automatic bit impl(int k);
        return k == 0 || k == 2 || (k >= 3 && k <= 6);
    endfunction

    task automatic model_step();
        int          n;
        logic [11:0] blk;
        blk = csr_addr & 12'hFE0;
        n   = int'(csr_addr[4:0]);
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                m_ctr[0][k] = 0;
                m_ctr[1][k] = 0;
                m_evt[k]    = 0;
            end
            m_inh = 0;
            return;
        end
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 32; k++) begin
                bit wl, wh, cnt;
                if (!impl(k)) continue;
                wl = csr_we && blk == 12'hB00 && n == k;
                wh = csr_we && blk == 12'hB80 && n == k;
                if (k == 0)      cnt = !m_inh[0];
                else if (k == 2) cnt = ins_exe && !m_inh[2];
                else             cnt = m_evt[k] >= 1 && m_evt[k] <= 8 && events[m_evt[k]-1] && !m_inh[k];
                if (wl) m_ctr[w][k] = (m_ctr[w][k] & 64'hFFFF_FFFF_0000_0000) | 64'(csr_wdata);
                if (wh) m_ctr[w][k] = (m_ctr[w][k] & 64'h0000_0000_FFFF_FFFF) | (64'(csr_wdata) << 32);
                if (!wl && !wh && cnt) m_ctr[w][k] = m_ctr[w][k] + 1;
                m_ctr[w][k] = m_ctr[w][k] & wmask(w);
            end
        end
        if (csr_we && csr_addr == 12'h320) m_inh = csr_wdata & 32'h7D;
        if (csr_we && blk == 12'h320 && n >= 3 && n <= 6) m_evt[n] = int'(csr_wdata[4:0]);
    endtask

    // Expected {hit64, rdata64, hit40, rdata40} for a read of address a.
    function automatic logic [65:0] mdl_obs(logic [11:0] a);
        logic [11:0] blk;
        int          n;
        logic        h;
        logic [31:0] d [2];
        blk = a & 12'hFE0;
        n   = int'(a[4:0]);
        h   = 1'b0;
        d[0] = '0;
        d[1] = '0;
        for (int w = 0; w < 2; w++) begin
            if ((blk == 12'hB00 || blk == 12'hC00) && impl(n)) begin
                h = 1'b1; d[w] = m_ctr[w][n][31:0];
            end else if ((blk == 12'hB80 || blk == 12'hC80) && impl(n)) begin
                h = 1'b1; d[w] = m_ctr[w][n][63:32];
            end else if (a == 12'h320) begin
                h = 1'b1; d[w] = m_inh;
            end else if (blk == 12'h320 && n >= 3 && n <= 6) begin
                h = 1'b1; d[w] = 32'(m_evt[n]);
            end
        end
        return {h, d[0], h, d[1]};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        rst = 1'b0; csr_we = 1'b0; ins_exe = 1'b0; events = '0;
    endtask

    task automatic wr(logic [11:0] a, logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
    endtask

    task automatic rd(logic [11:0] a);
        csr_addr = a;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; csr_addr = 12'hB00;
        tick();
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL reset_mcycle: got %h/%h want 0", rdata64, rdata40);
        end
        for (int i = 0; i < 9; i++) tick();
        rd(12'hB00);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd10, 1'b1, 32'd10}) begin
            errors++; $display("FAIL idle_mcycle: got %0d/%0d want 10", rdata64, rdata40);
        end
        rd(12'hB02);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL idle_minstret: got %0d/%0d want 0", rdata64, rdata40);
        end
        rd(12'hC00);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd12, 1'b1, 32'd12}) begin
            errors++; $display("FAIL shadow_cycle: got %0d/%0d want 12", rdata64, rdata40);
        end
        rd(12'h7C0);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== 66'd0) begin
            errors++; $display("FAIL unmapped: hit %b data %h want hit 0 data 0", hit64, rdata64);
        end
    endtask

    task automatic test_event_select();
        int n1 = 0, n0 = 0;
        wr(12'h323, 32'd2);
        while (n1 < 5 || n0 < 3) begin
            if (n1 < 5 && (n0 >= 3 || $urandom_range(1) == 1)) begin events = 8'h02; n1++; end
            else begin events = 8'h01; n0++; end
            tick();
            if ($urandom_range(2) == 0) tick();
        end
        rd(12'hB03);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd5, 1'b1, 32'd5}) begin
            errors++; $display("FAIL hpm3_count: got %0d/%0d want 5", rdata64, rdata40);
        end
        wr(12'h323, 32'hFFFF_FFFF);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd31, 1'b1, 32'd31}) begin
            errors++; $display("FAIL event_warl: got %0d want 31", rdata64);
        end
        for (int i = 0; i < 4; i++) begin events = 8'hFF; tick(); end
        wr(12'h323, 32'd9);
        for (int i = 0; i < 4; i++) begin events = 8'hFF; tick(); end
        rd(12'hB03);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd5, 1'b1, 32'd5}) begin
            errors++; $display("FAIL hpm3_bad_sel: got %0d/%0d want 5", rdata64, rdata40);
        end
    endtask

    task automatic test_wrap();
        wr(12'hB02, 32'hFFFF_FFFF);
        wr(12'hB82, 32'hFFFF_FFFF);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_00FF}) begin
            errors++; $display("FAIL hi_width: got %h/%h want ffffffff/000000ff", rdata64, rdata40);
        end
        csr_addr = 12'hB02; ins_exe = 1'b1;
        tick();
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL wrap_lo: got %h/%h want 0", rdata64, rdata40);
        end
        rd(12'hB82);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL wrap_hi: got %h/%h want 0", rdata64, rdata40);
        end
        wr(12'hB82, 32'h0000_FFFF);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'h0000_FFFF, 1'b1, 32'h0000_00FF}) begin
            errors++; $display("FAIL hi_trunc: got %h/%h want 0000ffff/000000ff", rdata64, rdata40);
        end
    endtask

    task automatic test_write_priority();
        ins_exe = 1'b1;
        wr(12'hB02, 32'h100);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'h100, 1'b1, 32'h100}) begin
            errors++; $display("FAIL write_wins: got %h/%h want 100", rdata64, rdata40);
        end
        wr(12'hC02, 32'h55);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'h100, 1'b1, 32'h100}) begin
            errors++; $display("FAIL shadow_ro: got %h/%h want 100", rdata64, rdata40);
        end
    endtask

    task automatic test_inhibit();
        longint unsigned cyc0, ret0, hpm0;
        int              pulses = 0;
        wr(12'h323, 32'd2);
        wr(12'h320, 32'h5);
        cyc0 = m_ctr[0][0]; ret0 = m_ctr[0][2]; hpm0 = m_ctr[0][3];
        for (int i = 0; i < 20; i++) begin
            ins_exe = 1'b1;
            events  = 8'($urandom);
            if (events[1]) pulses++;
            tick();
        end
        rd(12'hB00);
        checks++;
        if ({hit64, rdata64} !== {1'b1, cyc0[31:0]}) begin
            errors++; $display("FAIL inh_mcycle: got %0d want %0d", rdata64, cyc0[31:0]);
        end
        rd(12'hB02);
        checks++;
        if ({hit64, rdata64} !== {1'b1, ret0[31:0]}) begin
            errors++; $display("FAIL inh_minstret: got %0d want %0d", rdata64, ret0[31:0]);
        end
        rd(12'hB03);
        checks++;
        if ({hit64, rdata64} !== {1'b1, 32'(hpm0 + 64'(pulses))}) begin
            errors++; $display("FAIL inh_hpm3: got %0d want %0d", rdata64, hpm0 + 64'(pulses));
        end
        rd(12'h320);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'h5, 1'b1, 32'h5}) begin
            errors++; $display("FAIL inh_read: got %h want 5", rdata64);
        end
        wr(12'h320, 32'h2);
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL inh_bit1: got %h want 0", rdata64);
        end
        // The write cycle itself must still count under the old (clear) inhibit.
        cyc0 = m_ctr[0][0];
        wr(12'h320, 32'h1);
        rd(12'hB00);
        checks++;
        if (rdata64 !== 32'(cyc0 + 1)) begin
            errors++; $display("FAIL inh_timing: got %0d want %0d", rdata64, cyc0 + 1);
        end
        wr(12'h320, 32'h0);
    endtask

    task automatic test_random();
        logic [11:0] addrs [24] = '{12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB06, 12'hB07,
                                    12'hB80, 12'hB82, 12'hB84, 12'hB86, 12'hB87, 12'hC00,
                                    12'hC02, 12'hC85, 12'hC87, 12'hC81, 12'h320, 12'h321,
                                    12'h323, 12'h326, 12'h327, 12'h7C0, 12'hB1F, 12'h324};
        logic [65:0] exp;
        for (int i = 0; i < 400; i++) begin
            csr_addr  = addrs[$urandom_range(23)];
            csr_we    = ($urandom_range(7) == 0);
            csr_wdata = (csr_addr == 12'h320) ? ($urandom & 32'hFFFF_FFF0) : $urandom;
            ins_exe   = 1'($urandom);
            events    = 8'($urandom);
            tick();
            exp = mdl_obs(csr_addr);
            checks++;
            if ({hit64, rdata64, hit40, rdata40} !== exp) begin
                errors++;
                $display("FAIL random[%0d] addr %h: got %b/%h %b/%h want %h", i, csr_addr,
                         hit64, rdata64, hit40, rdata40, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        wr(12'h320, 32'h0);
        wr(12'h324, 32'd1);
        for (int i = 0; i < 6; i++) begin ins_exe = 1'b1; events = 8'hFF; tick(); end
        rst = 1'b1; csr_we = 1'b1; csr_addr = 12'hB00; csr_wdata = 32'h1234;
        ins_exe = 1'b1; events = 8'hFF;
        tick();
        checks++;
        if ({hit64, rdata64, hit40, rdata40} !== {1'b1, 32'd0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL rst_mcycle: got %h/%h want 0", rdata64, rdata40);
        end
        rd(12'hB02);
        checks++;
        if ({rdata64, rdata40} !== 64'd0) begin
            errors++; $display("FAIL rst_minstret: got %h/%h want 0", rdata64, rdata40);
        end
        rd(12'hB04);
        checks++;
        if ({rdata64, rdata40} !== 64'd0) begin
            errors++; $display("FAIL rst_hpm4: got %h/%h want 0", rdata64, rdata40);
        end
        rd(12'h324);
        checks++;
        if ({hit64, rdata64} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL rst_event4: got %h want 0", rdata64);
        end
        rd(12'h320);
        checks++;
        if ({hit64, rdata64} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL rst_inhibit: got %h want 0", rdata64);
        end
    endtask

    initial begin
        test_reset();
        test_event_select();
        test_wrap();
        test_write_priority();
        test_inhibit();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
